digital_gates: RTL and testbench
================================

Name: digital_gates

Overview:
- Parameterised two-input logic gate with a registered output.
- GATE_TYPE selects one fixed boolean function at elaboration time. The selected function is applied bitwise to port1 and port2, and the result is registered onto port3.
- Used as a small configurable logic primitive and as a gate-identification target: a bench drives the full input truth table and infers the function from port3.

Parameters:
- GATE_TYPE, default 0, selects the function:
  - 0 AND
  - 1 OR
  - 2 XOR
  - 3 NAND
  - 4 NOR
  - 5 XNOR
  - 6 A OR NOT B (port1 | ~port2)
  - any other value: AND
- WIDTH, default 1, bit width of port1, port2 and port3. Legal range is 1 or greater.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- port1  input  WIDTH  operand A.
- port2  input  WIDTH  operand B.
- port3  output  WIDTH  registered result of GATE_TYPE function(A, B).

Behaviour:
- Single clock domain. Reset is synchronous and active-low; there is no asynchronous reset path.
- Reset: at any rising clk edge with rst_n = 0, port3 <= all zeros.
  - This applies for every GATE_TYPE, including the inverting ones (3, 4, 5, 6). The reset value is 0, not the gate output for A = B = 0.
  - Reset has priority over the data update in the same cycle.
- Normal operation: at each rising clk edge with rst_n = 1, port3 <= f(port1, port2), evaluated bitwise per bit index i.
- Latency is exactly one clock: inputs sampled at edge N appear on port3 after edge N and hold until edge N+1.
- There is no combinational path from the inputs to port3.
- Truth table per bit, for inputs (A, B) = 00, 01, 10, 11:
  - AND 0001
  - OR 0111
  - XOR 0110
  - NAND 1110
  - NOR 1000
  - XNOR 1001
  - A|~B 1011
- Out-of-range GATE_TYPE (negative or greater than 6) behaves exactly as AND. It is not an elaboration error.
- The function is fixed at elaboration; there is no runtime select and no enable, so port3 updates every non-reset cycle.
- Reset mid-operation: the first edge with rst_n low clears port3 irrespective of the inputs. The first edge after rst_n returns high loads f(port1, port2) sampled at that edge.
- X handling: no requirement beyond standard synthesizable operator semantics. Outputs are fully defined whenever the inputs are 0 or 1.
- The implementation contains no latches and no initial blocks relied upon for function.

Test Plan:
- GATE_TYPE = 0..6, WIDTH = 1, rst_n = 1:
  - Stimulus: drive (A, B) = 00, 01, 10, 11 on successive cycles.
  - Response: port3 shows the truth-table column for that gate one cycle later. Examples: XOR gives 0, 1, 1, 0; A|~B gives 1, 0, 1, 1.
- GATE_TYPE = 9 (out of range):
  - Stimulus: the same four-vector sweep.
  - Response: port3 = 0, 0, 0, 1 (AND behaviour).
- GATE_TYPE = 3 (NAND):
  - Stimulus: hold rst_n = 0 for 2 edges with A = B = 0.
  - Response: port3 = 0 during reset, then 1 on the first edge after rst_n goes high.
- GATE_TYPE = 1 (OR), WIDTH = 1:
  - Stimulus: A = 1, B = 0 steady, then assert rst_n = 0 for one edge mid-stream.
  - Response: port3 = 1, drops to 0 at the reset edge, returns to 1 on the next edge with rst_n = 1.
- GATE_TYPE = 2 (XOR), WIDTH = 8:
  - Stimulus: A = 8'hF0, B = 8'h3C.
  - Response: port3 = 8'hCC one cycle later.
- Latency check, GATE_TYPE = 0 (AND):
  - Stimulus: change A from 0 to 1 with B = 1 between edges.
  - Response: port3 stays 0 until the next rising clk edge, then becomes 1 with no glitch before it.

Source files
------------

// File: rtl/digital_gates_if.sv
// Operand and result bundle for digital_gates: port1/port2 in, registered port3 out.
// The driver holds the master modport, the gate holds the slave modport.
interface digital_gates_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] port1;
   logic [WIDTH-1:0] port2;
   logic [WIDTH-1:0] port3;

   modport master (
      output port1,
      output port2,
      input  port3
   );

   modport slave (
      input  port1,
      input  port2,
      output port3
   );
endinterface

// File: rtl/digital_gates.sv
// Bitwise two-input gate chosen by GATE_TYPE at elaboration; port3 is registered, one clock of latency.
// No backpressure: port3 updates on every edge, and a low rst_n on that edge clears it to zero.
module digital_gates #(
   parameter int GATE_TYPE = 0,
   parameter int WIDTH     = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   digital_gates_if.slave gif
);

   logic [WIDTH-1:0] port3_d;
   logic [WIDTH-1:0] port3_q;

   // Any GATE_TYPE outside 0..6, including negative values, falls back to AND.
   always_comb begin
      port3_d = gif.port1 & gif.port2;
      case (GATE_TYPE)
         0:       port3_d = gif.port1 & gif.port2;
         1:       port3_d = gif.port1 | gif.port2;
         2:       port3_d = gif.port1 ^ gif.port2;
         3:       port3_d = ~(gif.port1 & gif.port2);
         4:       port3_d = ~(gif.port1 | gif.port2);
         5:       port3_d = ~(gif.port1 ^ gif.port2);
         6:       port3_d = gif.port1 | ~gif.port2;
         default: port3_d = gif.port1 & gif.port2;
      endcase
   end

   // Reset value is zero even for the inverting gates.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         port3_q <= '0;
      end else begin
         port3_q <= port3_d;
      end
   end

   assign gif.port3 = port3_q;

endmodule

// File: tb/tb_digital_gates.sv
// Drives every gate flavour (8-bit and 1-bit) from shared operands and checks port3 against a truth-table model.
module tb_digital_gates;

   localparam int N = 9;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] q8 [N];
   logic       q1 [N];
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < N; g++) begin : g_dut
         localparam int GT = (g < 7) ? g : ((g == 7) ? 9 : -2);

         digital_gates_if #(.WIDTH(8)) if8 ();
         digital_gates_if #(.WIDTH(1)) if1 ();

         assign if8.port1 = a;
         assign if8.port2 = b;
         assign if1.port1 = a[0];
         assign if1.port2 = b[0];

         digital_gates #(.GATE_TYPE(GT), .WIDTH(8)) u_w8 (
            .clk   (clk),
            .rst_n (rst_n),
            .gif   (if8)
         );

         digital_gates #(.GATE_TYPE(GT), .WIDTH(1)) u_w1 (
            .clk   (clk),
            .rst_n (rst_n),
            .gif   (if1)
         );

         assign q8[g] = if8.port3;
         assign q1[g] = if1.port3;
      end
   endgenerate

   function automatic int gate_type(input int g);
      if (g < 7)       return g;
      else if (g == 7) return 9;
      else             return -2;
   endfunction

   // Entry [idx] is the output for {A,B} == idx, read straight off the gate's truth table.
   function automatic logic [3:0] truth(input int t);
      case (t)
         1:       return 4'b1110;
         2:       return 4'b0110;
         3:       return 4'b0111;
         4:       return 4'b0001;
         5:       return 4'b1001;
         6:       return 4'b1101;
         default: return 4'b1000;
      endcase
   endfunction

   function automatic logic [7:0] model(input int t, input logic [7:0] x, input logic [7:0] y);
      logic [3:0] tt;
      logic [7:0] r;
      tt = truth(t);
      r  = '0;
      for (int i = 0; i < 8; i++) begin
         r[i] = tt[{x[i], y[i]}];
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Apply inputs, take one edge, then compare every instance against the model.
   task automatic step(input logic r, input logic [7:0] x, input logic [7:0] y);
      logic [7:0] e;
      rst_n = r;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      for (int g = 0; g < N; g++) begin
         e = r ? model(gate_type(g), x, y) : 8'h00;
         check($sformatf("t%0d_w8", gate_type(g)), q8[g], e);
         check($sformatf("t%0d_w1", gate_type(g)), {7'b0, q1[g]}, {7'b0, e[0]});
      end
   endtask

   initial begin
      rst_n = 1'b0;
      a     = 8'h00;
      b     = 8'h00;

      // Reset held for two edges: all outputs zero, including inverting gates.
      step(1'b0, 8'h00, 8'h00);
      step(1'b0, 8'h00, 8'h00);
      check("nand_in_rst", {7'b0, q1[3]}, 8'h00);
      step(1'b1, 8'h00, 8'h00);
      check("nand_after_rst", {7'b0, q1[3]}, 8'h01);

      // Full truth-table sweep 00, 01, 10, 11.
      for (int v = 0; v < 4; v++) begin
         step(1'b1, {8{v[1]}}, {8{v[0]}});
      end

      step(1'b1, 8'hF0, 8'h3C);
      check("xor_w8_f0_3c", q8[2], 8'hCC);

      // OR with a one-edge reset in the middle of a steady stream.
      step(1'b1, 8'h01, 8'h00);
      check("or_pre_rst", {7'b0, q1[1]}, 8'h01);
      step(1'b0, 8'h01, 8'h00);
      check("or_at_rst", {7'b0, q1[1]}, 8'h00);
      step(1'b1, 8'h01, 8'h00);
      check("or_post_rst", {7'b0, q1[1]}, 8'h01);

      // AND: a change between edges must not reach port3 before the next edge.
      step(1'b1, 8'h00, 8'hFF);
      a = 8'hFF;
      #3;
      check("and_no_comb_w1", {7'b0, q1[0]}, 8'h00);
      check("and_no_comb_w8", q8[0], 8'h00);
      @(posedge clk);
      #1;
      check("and_next_edge_w1", {7'b0, q1[0]}, 8'h01);
      check("and_next_edge_w8", q8[0], 8'hFF);

      repeat (300) begin
         step(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0, 8'($urandom), 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
